fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL take parameter DEPTH, default 4, giving queue entries; legal values are powers of two, 2 to 16.
REQ-002 The module SHALL take parameter PC_INIT, default 32'h0, giving the fetch address after reset.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port: CLK  in  1  system clock, rising edge.
REQ-005 Port: RST  in  1  asynchronous active-high reset.
REQ-006 Port: ihit  in  1  instruction memory returned imemload for imemaddr this cycle.
REQ-007 Port: imemload  in  32  instruction word.
REQ-008 Port: imemREN  out  1  fetch request.
REQ-009 Port: imemaddr  out  32  fetch address (current fetch PC).
REQ-010 Port: redirect  in  1  branch/jump resolved taken; flush queue and refetch.
REQ-011 Port: redirect_pc  in  32  new fetch address, word aligned.
REQ-012 Port: halt  in  1  halt decoded; stop fetching.
REQ-013 Port: deq  in  1  decode consumes head entry.
REQ-014 Port: valid  out  1  head entry present.
REQ-015 Port: instr_out  out  32  head instruction.
REQ-016 Port: npc_out  out  32  head fetch address + 4.
REQ-017 Port: count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-018 FSM states SHALL be FETCH, FULL, HALTED; imemREN SHALL be 1 only in FETCH.
REQ-019 In FETCH with ihit=1 and redirect=0, the block SHALL push {imemload, imemaddr+4} and advance PC by 4 at the next edge.
REQ-020 PC arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 gives 32'h0.
REQ-021 A push making count equal DEPTH SHALL move FETCH to FULL.
REQ-022 A pop in FULL SHALL return to FETCH next cycle; no push in FULL even if ihit=1.
REQ-023 deq with valid=1 SHALL pop the head at the edge; deq with valid=0 SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 valid SHALL equal (count!=0); instr_out/npc_out SHALL be head data, registered with zero-latency lookahead; they SHALL be 0 when empty.
REQ-027 redirect SHALL win over push, pop and halt in the same cycle: queue emptied, PC=redirect_pc, state FETCH, and same-cycle ihit data discarded.
REQ-028 halt=1 (without redirect) SHALL enter HALTED next cycle; same-cycle push still completes.
REQ-029 HALTED SHALL be left only by redirect or reset; queued entries SHALL remain poppable while HALTED.
REQ-030 Fetch-to-valid latency SHALL be one cycle after ihit.

Reset
REQ-031 While RST=1: PC=PC_INIT, count=0, pointers=0, state FETCH, valid=0, instr_out=0, npc_out=0, imemaddr=PC_INIT, imemREN=1.
REQ-032 Reset mid-operation SHALL discard all entries and any in-progress fetch immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro FETCH_QUEUE_STATS_EN defined SHALL add output stall_cnt (32): +1 per cycle with imemREN=1 and ihit=0, saturating at 32'hFFFFFFFF, cleared by reset only.
REQ-034 Without FETCH_QUEUE_STATS_EN the port and counter SHALL not exist; all other behaviour is identical.

Structure
REQ-035 word_t and a new struct fq_entry_t {word_t instr; word_t npc;} SHALL live in cpu_types_pkg; the FSM state enum SHALL be package-defined as fq_state_t.
REQ-036 Storage and pointers SHALL be the sub-module fq_fifo, parametrised by DEPTH and fq_entry_t; FSM and PC logic stay in fetch_queue.

Verification
REQ-037 Reset, ihit=1 for 3 cycles, deq=0 -> entries npc 4, 8, 12; count=3; imemaddr=12.
REQ-038 DEPTH=4, ihit=1 continuously, deq=0 -> count=4, state FULL, imemREN=0; one deq -> count=3, imemREN=1 next cycle.
REQ-039 Queue with 2 entries, redirect=1, redirect_pc=32'h100, ihit=1, deq=1 same cycle -> count=0, valid=0, imemaddr=32'h100.
REQ-040 halt=1 with 3 entries -> imemREN=0; 3 deqs drain to count=0; redirect to 32'h40 -> FETCH, imemaddr=32'h40.
REQ-041 redirect_pc=32'hFFFFFFFC, ihit=1 -> npc_out=32'h0, next imemaddr=32'h0; RST pulse mid-stream -> count=0, imemaddr=PC_INIT immediately.
REQ-042 With FETCH_QUEUE_STATS_EN, 5 cycles imemREN=1 and ihit=0 -> stall_cnt=5.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-queue entry and fetch-queue FSM state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // One queued fetch: the instruction and the address of the following word.
  typedef struct packed {
    word_t instr;
    word_t npc;
  } fq_entry_t;

  typedef enum logic [1:0] {
    FETCH,
    FULL,
    HALTED
  } fq_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic word_t pc_plus4(word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Storage and pointers for the fetch queue. The head entry is kept in a
// register that is loaded with the entry that will be at the head after each
// edge, so rdata is valid with no read latency and reads as zero when empty.
module fq_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fq_entry_t
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   rptr_nxt;
  logic [CW-1:0]   count_q, count_d;
  entry_t          head_q, head_d;

  // Next pointers, occupancy and lookahead head entry.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    head_d   = head_q;
    rptr_nxt = rptr_q + AW'(1);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      head_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_nxt;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (count_d == '0) begin
        head_d = '0;
      end else if (pop) begin
        // Popping the last stored entry: the new head is the one arriving now.
        head_d = (count_q == CW'(1)) ? wdata : mem[rptr_nxt];
      end else if (count_q == '0) begin
        head_d = wdata;
      end
    end
  end

  // Entry storage; needs no reset since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wptr_q] <= wdata;
  end

  // Pointer, count and head registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign rdata = head_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch PC, FETCH/FULL/HALTED control and a queue of
// fetched {instr, npc} entries for decode.
// Optional feature macro: FETCH_QUEUE_STATS_EN adds the stall_cnt output.
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter word_t       PC_INIT = 32'h0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic [31:0]            imemload,
  output logic                   imemREN,
  output logic [31:0]            imemaddr,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt,
  input  logic                   deq,
  output logic                   valid,
  output logic [31:0]            instr_out,
  output logic [31:0]            npc_out,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fq_state_t     state_q, state_d;
  word_t         pc_q, pc_d;
  logic          push, pop, flush;
  logic [CW-1:0] count_after;
  fq_entry_t     push_entry;
  fq_entry_t     head;

  // Control: redirect overrides everything, else FSM decides push and state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imemREN     = (state_q == FETCH);
    flush       = redirect;
    push        = !redirect && (state_q == FETCH) && ihit;
    pop         = !redirect && deq && valid;
    push_entry  = '{instr: imemload, npc: pc_plus4(pc_q)};
    case ({push, pop})
      2'b10:   count_after = count + CW'(1);
      2'b01:   count_after = count - CW'(1);
      default: count_after = count;
    endcase
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = FETCH;
    end else begin
      if (push) pc_d = pc_plus4(pc_q);
      unique case (state_q)
        FETCH: begin
          if (halt)                           state_d = HALTED;
          else if (count_after == CW'(DEPTH)) state_d = FULL;
        end
        FULL: begin
          if (halt)     state_d = HALTED;
          else if (pop) state_d = FETCH;
        end
        HALTED:  state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fq_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(fq_entry_t)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .flush(flush),
    .push (push),
    .wdata(push_entry),
    .pop  (pop),
    .rdata(head),
    .count(count)
  );

  assign imemaddr  = pc_q;
  assign valid     = (count != '0);
  assign instr_out = head.instr;
  assign npc_out   = head.npc;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_q;

  // Count cycles where a fetch is requested but memory has not answered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
    end else if (imemREN && !ihit && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4, PC_INIT=0).
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        deq;
  logic        valid;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_e;

  always #5 CLK = ~CLK;

  fetch_queue #(
    .DEPTH  (4),
    .PC_INIT(32'h0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .deq        (deq),
    .valid      (valid),
    .instr_out  (instr_out),
    .npc_out    (npc_out),
    .count      (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic [31:0] ld, input logic dq,
                       input logic rd, input logic [31:0] rpc, input logic hl);
    ihit        = ih;
    imemload    = ld;
    deq         = dq;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every accepted dequeue is checked against the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST && valid && deq && !redirect) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got instr=%h npc=%h required no entry", instr_out, npc_out);
      end else begin
        exp_e = sb_q.pop_front();
        if ({instr_out, npc_out} !== exp_e) begin
          n_err++;
          $display("FAIL pop_entry: got instr=%h npc=%h required instr=%h npc=%h",
                   instr_out, npc_out, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_imemREN", 32'(imemREN), 32'd1);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_npc", npc_out, 32'h0);
    RST = 1'b0;

    // Three fetches, no dequeue.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1111_0000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      sb_q.push_back({32'h1111_0000 + 32'(i), 32'(4 * (i + 1))});
      tick();
      if (i == 0) chk("latency_valid", 32'(valid), 32'd1);
    end
    chk("fill3_count", 32'(count), 32'd3);
    chk("fill3_imemaddr", imemaddr, 32'd12);
    chk("fill3_head_instr", instr_out, 32'h1111_0000);
    chk("fill3_head_npc", npc_out, 32'd4);

    // Fill to DEPTH, then hold in FULL.
    drive(1'b1, 32'h1111_0003, 1'b0, 1'b0, 32'h0, 1'b0);
    sb_q.push_back({32'h1111_0003, 32'd16});
    tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_imemREN", 32'(imemREN), 32'd0);
    chk("full_imemaddr", imemaddr, 32'd16);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("full_nopush_count", 32'(count), 32'd4);
    chk("full_nopush_imemaddr", imemaddr, 32'd16);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_imemREN", 32'(imemREN), 32'd1);

    // Simultaneous push and pop; write pointer wraps.
    drive(1'b1, 32'h2222_0004, 1'b1, 1'b0, 32'h0, 1'b0);
    sb_q.push_back({32'h2222_0004, 32'd20});
    tick();
    chk("pushpop_count", 32'(count), 32'd3);
    chk("pushpop_imemaddr", imemaddr, 32'd20);

    // Down to two entries, then redirect with ihit and deq in the same cycle.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("pop_count", 32'(count), 32'd2);
    drive(1'b1, 32'hBAD0_0000, 1'b1, 1'b1, 32'h100, 1'b0);
    sb_q.delete();
    tick();
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(valid), 32'd0);
    chk("redir_imemaddr", imemaddr, 32'h100);
    chk("redir_instr_zero", instr_out, 32'h0);
    chk("redir_npc_zero", npc_out, 32'h0);

    // Halt with the third push in the same cycle; drain while halted.
    drive(1'b1, 32'h3333_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    sb_q.push_back({32'h3333_0000, 32'h104});
    tick();
    drive(1'b1, 32'h3333_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    sb_q.push_back({32'h3333_0001, 32'h108});
    tick();
    drive(1'b1, 32'h3333_0002, 1'b0, 1'b0, 32'h0, 1'b1);
    sb_q.push_back({32'h3333_0002, 32'h10C});
    tick();
    chk("halt_count", 32'(count), 32'd3);
    chk("halt_imemREN", 32'(imemREN), 32'd0);
    chk("halt_imemaddr", imemaddr, 32'h10C);
    drive(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("halted_nopush_count", 32'(count), 32'd3);
    chk("halted_stays", 32'(imemREN), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(valid), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("empty_deq_ignored", 32'(count), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
    tick();
    chk("unhalt_imemREN", 32'(imemREN), 32'd1);
    chk("unhalt_imemaddr", imemaddr, 32'h40);

    // PC wrap at the top of the address space.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    chk("wrap_redir_imemaddr", imemaddr, 32'hFFFF_FFFC);
    drive(1'b1, 32'h4444_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    sb_q.push_back({32'h4444_0000, 32'h0});
    tick();
    chk("wrap_npc", npc_out, 32'h0);
    chk("wrap_imemaddr", imemaddr, 32'h0);
    chk("wrap_instr", instr_out, 32'h4444_0000);
    drive(1'b1, 32'h4444_0001, 1'b1, 1'b0, 32'h0, 1'b0);
    sb_q.push_back({32'h4444_0001, 32'h4});
    tick();
    chk("stream_count", 32'(count), 32'd1);
    chk("stream_imemaddr", imemaddr, 32'h4);

    // Reset mid-cycle, between clock edges.
    #2;
    RST = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    sb_q.delete();
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_imemaddr", imemaddr, 32'h0);
    chk("async_rst_imemREN", 32'(imemREN), 32'd1);
    chk("async_rst_instr", instr_out, 32'h0);
    tick();
    RST = 1'b0;

    // Five stalled fetch cycles.
    repeat (5) tick();
    chk("stall_imemaddr", imemaddr, 32'h0);
    chk("stall_count", 32'(count), 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("stall_cnt", stall_cnt, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
